// File: rtl/led_panel_pkg.sv
// Shared types and geometry for the 64x64 HUB75 panel (1/32 scan) datapath.
package led_panel_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LO,
      HI,
      LATCH,
      ON,
      ADV
   } state_e;

   localparam int unsigned COL_W  = 6;
   localparam int unsigned ROW_W  = 5;
   localparam int unsigned N_COLS = 64;
   localparam int unsigned N_ROWS = 32;

endpackage

// File: rtl/bcm_oe_timer.sv
// Loadable down-counter timing the output-enable window of one BCM bit-plane.
module bcm_oe_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             done_o
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   // Flags the last lit cycle so the window spans exactly the loaded count.
   assign done_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan FSM: shifts RGB columns, latches rows and sequences BCM bit-planes.
module hub75_scan_ctrl
   import led_panel_pkg::*;
#(
   parameter int unsigned PWM_BITS = 4,
   parameter int unsigned BASE_ON  = 16,
   parameter int unsigned PLANE_W  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               col_max,
   input  logic               row_max,
   input  logic [ROW_W-1:0]   select_row,
   input  logic [2:0]         rgb_top,
   input  logic [2:0]         rgb_bot,
   output logic               col_inc,
   output logic               row_inc,
   output logic [PLANE_W-1:0] plane,
   output logic [2:0]         panel_rgb1,
   output logic [2:0]         panel_rgb2,
   output logic               panel_clk,
   output logic               panel_lat,
   output logic               panel_oe_n,
   output logic [ROW_W-1:0]   addr,
   output logic               frame_start
);

   localparam int unsigned MAX_ON = BASE_ON << (PWM_BITS - 1);
   localparam int unsigned CNT_W  = $clog2(MAX_ON + 1);
   localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(PWM_BITS - 1);

   state_e             state_q;
   logic [PLANE_W-1:0] plane_q;
   logic [2:0]         rgb1_q;
   logic [2:0]         rgb2_q;
   logic               clk_q;
   logic               lat_q;
   logic               oe_n_q;
   logic               fs_q;
   logic [ROW_W-1:0]   addr_q;

   logic               last_plane;
   logic [CNT_W-1:0]   on_len;
   logic               tmr_done;

   assign last_plane = (plane_q == LAST_PLANE);
   assign on_len     = CNT_W'(BASE_ON) << plane_q;

   bcm_oe_timer #(
      .CNT_W(CNT_W)
   ) u_oe_timer (
      .clk       (clk),
      .rst       (rst),
      .load_i    (state_q == LATCH),
      .load_val_i(on_len),
      .dec_i     (state_q == ON),
      .done_o    (tmr_done)
   );

   // Panel strobes are set on the transition into their state, so each one
   // is high exactly while the state register holds that state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         plane_q <= '0;
         rgb1_q  <= '0;
         rgb2_q  <= '0;
         clk_q   <= 1'b0;
         lat_q   <= 1'b0;
         oe_n_q  <= 1'b1;
         fs_q    <= 1'b0;
         addr_q  <= '0;
      end else begin
         clk_q  <= 1'b0;
         lat_q  <= 1'b0;
         oe_n_q <= 1'b1;
         fs_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (en) state_q <= SETUP;
            end
            SETUP: begin
               rgb1_q  <= rgb_top;
               rgb2_q  <= rgb_bot;
               state_q <= LO;
            end
            LO: begin
               clk_q   <= 1'b1;
               state_q <= HI;
            end
            HI: begin
               if (col_max) begin
                  lat_q   <= 1'b1;
                  state_q <= LATCH;
               end else begin
                  state_q <= SETUP;
               end
            end
            LATCH: begin
               addr_q  <= select_row;
               oe_n_q  <= 1'b0;
               state_q <= ON;
            end
            ON: begin
               if (tmr_done) begin
                  fs_q    <= last_plane && row_max;
                  state_q <= ADV;
               end else begin
                  oe_n_q <= 1'b0;
               end
            end
            ADV: begin
               plane_q <= last_plane ? '0 : plane_q + 1'b1;
               state_q <= en ? SETUP : IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign col_inc     = (state_q == HI);
   assign row_inc     = (state_q == ADV) && last_plane;
   assign plane       = plane_q;
   assign panel_rgb1  = rgb1_q;
   assign panel_rgb2  = rgb2_q;
   assign panel_clk   = clk_q;
   assign panel_lat   = lat_q;
   assign panel_oe_n  = oe_n_q;
   assign addr        = addr_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl with a behavioural scan_counters alongside.
module tb_hub75_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [2:0] rgb_top;
   logic [2:0] rgb_bot;
   logic       col_inc;
   logic       row_inc;
   logic [1:0] plane;
   logic [2:0] panel_rgb1;
   logic [2:0] panel_rgb2;
   logic       panel_clk;
   logic       panel_lat;
   logic       panel_oe_n;
   logic [4:0] addr;
   logic       frame_start;

   logic [5:0] col_m;
   logic [4:0] row_m;
   logic       col_max;
   logic       row_max;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t_setup0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (rst) begin
         col_m <= '0;
         row_m <= '0;
      end else begin
         if (col_inc) col_m <= col_m + 6'd1;
         if (row_inc) row_m <= row_m + 5'd1;
      end
   end

   assign col_max = (col_m == 6'd63);
   assign row_max = (row_m == 5'd31);

   hub75_scan_ctrl #(
      .PWM_BITS(4),
      .BASE_ON (16),
      .PLANE_W (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .col_max    (col_max),
      .row_max    (row_max),
      .select_row (row_m),
      .rgb_top    (rgb_top),
      .rgb_bot    (rgb_bot),
      .col_inc    (col_inc),
      .row_inc    (row_inc),
      .plane      (plane),
      .panel_rgb1 (panel_rgb1),
      .panel_rgb2 (panel_rgb2),
      .panel_clk  (panel_clk),
      .panel_lat  (panel_lat),
      .panel_oe_n (panel_oe_n),
      .addr       (addr),
      .frame_start(frame_start)
   );

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b0; rgb_top = 3'b000; rgb_bot = 3'b000;
      tick; tick;
      total++;
      if (panel_oe_n !== 1'b1) begin
         bad++; $display("FAIL reset_oe_n got=%b want=1", panel_oe_n);
      end
      total++;
      if ({col_inc, row_inc, plane, panel_rgb1, panel_rgb2, panel_clk, panel_lat, addr, frame_start} !== 18'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=0",
                  {col_inc, row_inc, plane, panel_rgb1, panel_rgb2, panel_clk, panel_lat, addr, frame_start});
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick;
         total++;
         if ({panel_oe_n, panel_clk, panel_lat, col_inc} !== 4'b1000) begin
            bad++;
            $display("FAIL idle_quiet got=%b want=1000", {panel_oe_n, panel_clk, panel_lat, col_inc});
         end
      end
   endtask

   task automatic test_shift;
      int   pulses = 0;
      int   low_run = 0;
      logic prev = 1'b0;
      logic got_lat = 1'b0;
      rgb_top = 3'b101; rgb_bot = 3'b010; en = 1'b1;
      tick;
      t_setup0 = cyc;
      for (int i = 0; i < 400 && !got_lat; i++) begin
         if (i > 0) tick;
         if (panel_clk) begin
            total++;
            if (prev !== 1'b0 || low_run !== 2) begin
               bad++; $display("FAIL clk_shape prev_high=%0b low_run=%0d want 0/2", prev, low_run);
            end
            total++;
            if (panel_rgb1 !== 3'b101 || panel_rgb2 !== 3'b010) begin
               bad++; $display("FAIL rgb_at_edge got=%b/%b want=101/010", panel_rgb1, panel_rgb2);
            end
            pulses++;
            low_run = 0;
         end else begin
            low_run++;
         end
         if (panel_lat) begin
            got_lat = 1'b1;
            total++;
            if (pulses !== 64) begin
               bad++; $display("FAIL pulses_before_lat got=%0d want=64", pulses);
            end
            total++;
            if (panel_oe_n !== 1'b1) begin
               bad++; $display("FAIL oe_in_latch got=%b want=1", panel_oe_n);
            end
         end
         prev = panel_clk;
      end
      total++;
      if (!got_lat) begin
         bad++; $display("FAIL lat_timeout got=none want=latch");
      end
      tick;
      total++;
      if (addr !== 5'd0 || panel_oe_n !== 1'b0 || panel_lat !== 1'b0) begin
         bad++; $display("FAIL first_on addr=%0d oe_n=%b lat=%b want 0/0/0", addr, panel_oe_n, panel_lat);
      end
   endtask

   // Entered on the first lit cycle of row 0 plane 0, hence oe_low starts at 1.
   task automatic test_planes;
      int   want_w[4] = '{16, 32, 64, 128};
      int   idx = 0;
      int   oe_low = 1;
      logic done = 1'b0;
      for (int i = 0; i < 1500 && !done; i++) begin
         tick;
         total++;
         if ((panel_lat || panel_clk) && panel_oe_n === 1'b0) begin
            bad++; $display("FAIL strobe_overlap lat=%b clk=%b oe_n=%b", panel_lat, panel_clk, panel_oe_n);
         end
         if (!panel_oe_n) begin
            oe_low++;
         end else if (oe_low > 0) begin
            total++;
            if (idx < 4 && oe_low !== want_w[idx]) begin
               bad++; $display("FAIL oe_width plane=%0d got=%0d want=%0d", idx, oe_low, want_w[idx]);
            end
            total++;
            if (row_inc !== (idx == 3)) begin
               bad++; $display("FAIL row_inc_after_window plane=%0d got=%b want=%b", idx, row_inc, idx == 3);
            end
            idx++;
            oe_low = 0;
         end
         if (panel_lat) begin
            total++;
            if (plane !== 2'(idx % 4)) begin
               bad++; $display("FAIL plane_at_lat got=%0d want=%0d", plane, idx % 4);
            end
            if (idx == 4) begin
               tick;
               total++;
               if (addr !== 5'd1) begin
                  bad++; $display("FAIL addr_row1 got=%0d want=1", addr);
               end
               done = 1'b1;
            end
         end
      end
      total++;
      if (!done) begin
         bad++; $display("FAIL planes_timeout windows=%0d want=4", idx);
      end
   endtask

   // frame_start sits in the final ADV, the last of the 32512 frame cycles.
   task automatic test_frame;
      logic found = 1'b0;
      int   t_fs;
      for (int i = 0; i < 40000 && !found; i++) begin
         tick;
         if (frame_start) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL frame_timeout got=none want=frame_start");
         return;
      end
      t_fs = cyc;
      total++;
      if (t_fs - t_setup0 !== 32511) begin
         bad++; $display("FAIL frame_offset got=%0d want=32511", t_fs - t_setup0);
      end
      total++;
      if (row_inc !== 1'b1) begin
         bad++; $display("FAIL fs_row_inc got=%b want=1", row_inc);
      end
      tick;
      total++;
      if (frame_start !== 1'b0 || plane !== 2'd0 || row_m !== 5'd0) begin
         bad++; $display("FAIL frame_wrap fs=%b plane=%0d row=%0d want 0/0/0", frame_start, plane, row_m);
      end
      found = 1'b0;
      for (int i = 0; i < 40000 && !found; i++) begin
         tick;
         if (frame_start) found = 1'b1;
      end
      total++;
      if (!found || cyc - t_fs !== 32512) begin
         bad++; $display("FAIL frame_period found=%b got=%0d want=32512", found, cyc - t_fs);
      end
   endtask

   task automatic test_en_drop;
      logic hit = 1'b0;
      logic ended = 1'b0;
      int   oe_low = 0;
      rst = 1'b1; en = 1'b1;
      tick; tick;
      rst = 1'b0;
      for (int i = 0; i < 8000 && !hit; i++) begin
         tick;
         if (row_m == 5'd5 && plane == 2'd2 && panel_clk) hit = 1'b1;
      end
      total++;
      if (!hit) begin
         bad++; $display("FAIL reach_row5_plane2 got=none want=shift");
      end
      en = 1'b0;
      for (int i = 0; i < 600 && !ended; i++) begin
         tick;
         if (!panel_oe_n) begin
            oe_low++;
         end else if (oe_low > 0) begin
            ended = 1'b1;
            total++;
            if (oe_low !== 64) begin
               bad++; $display("FAIL drop_oe_width got=%0d want=64", oe_low);
            end
            total++;
            if (row_inc !== 1'b0) begin
               bad++; $display("FAIL drop_row_inc got=%b want=0", row_inc);
            end
         end
      end
      total++;
      if (!ended) begin
         bad++; $display("FAIL drop_timeout got=none want=window");
      end
      for (int i = 0; i < 20; i++) begin
         tick;
         total++;
         if ({panel_oe_n, panel_clk, panel_lat, col_inc} !== 4'b1000) begin
            bad++; $display("FAIL drop_idle got=%b want=1000", {panel_oe_n, panel_clk, panel_lat, col_inc});
         end
      end
      total++;
      if (plane !== 2'd3 || row_m !== 5'd5) begin
         bad++; $display("FAIL drop_resume_point plane=%0d row=%0d want 3/5", plane, row_m);
      end
      en = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin
         tick;
         if (panel_lat) hit = 1'b1;
      end
      tick;
      total++;
      if (!hit || addr !== 5'd5 || plane !== 2'd3 || panel_oe_n !== 1'b0) begin
         bad++;
         $display("FAIL resume lat=%b addr=%0d plane=%0d oe_n=%b want 1/5/3/0", hit, addr, plane, panel_oe_n);
      end
   endtask

   task automatic test_rst_on;
      for (int i = 0; i < 40; i++) tick;
      total++;
      if (panel_oe_n !== 1'b0) begin
         bad++; $display("FAIL pre_rst_on got oe_n=%b want=0", panel_oe_n);
      end
      rst = 1'b1;
      tick;
      total++;
      if (panel_oe_n !== 1'b1 || plane !== 2'd0 || addr !== 5'd0) begin
         bad++; $display("FAIL rst_on oe_n=%b plane=%0d addr=%0d want 1/0/0", panel_oe_n, plane, addr);
      end
      total++;
      if ({panel_clk, panel_lat, frame_start, col_inc, row_inc, panel_rgb1, panel_rgb2} !== 11'd0
          || col_m !== 6'd0 || row_m !== 5'd0) begin
         bad++;
         $display("FAIL rst_on_rest strobes=%b col=%0d row=%0d want 0/0/0",
                  {panel_clk, panel_lat, frame_start, col_inc, row_inc, panel_rgb1, panel_rgb2}, col_m, row_m);
      end
      en = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         total++;
         if ({panel_oe_n, panel_clk, panel_lat, col_inc} !== 4'b1000) begin
            bad++; $display("FAIL post_rst_idle got=%b want=1000", {panel_oe_n, panel_clk, panel_lat, col_inc});
         end
      end
   endtask

   initial begin
      test_reset();
      test_shift();
      test_planes();
      test_frame();
      test_en_drop();
      test_rst_on();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Timing and control FSM for the 64x64 HUB75 LED panel (1/32 scan, top/bottom halves).
- Sits directly upstream of scan_counters: it drives col_inc/row_inc and consumes col_max/row_max/select_row.
- It also shifts bit-sliced RGB data into the panel, generates panel_clk/panel_lat/panel_oe_n/addr, and sequences Binary Code Modulation (BCM) bit-planes.

Parameters:
- PWM_BITS, 4, number of BCM bit-planes per row (colour depth per channel).
- BASE_ON, 16, OE-active cycles for bit-plane 0; plane p is lit BASE_ON<<p cycles.
- PLANE_W, 2, width of the plane index; must satisfy 2**PLANE_W >= PWM_BITS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; sampled in IDLE and ADV only
- col_max  in  1  from scan_counters, select_col==63
- row_max  in  1  from scan_counters, select_row==31
- select_row  in  5  from scan_counters, current row
- rgb_top  in  3  {r,g,b} bit for (select_col, select_row, plane), upper half; valid during SETUP
- rgb_bot  in  3  same for row select_row+32
- col_inc  out  1  to scan_counters
- row_inc  out  1  to scan_counters
- plane  out  PLANE_W  current bit-plane, to pixel fetch stage
- panel_rgb1  out  3  upper-half data to panel
- panel_rgb2  out  3  lower-half data to panel
- panel_clk  out  1  panel shift clock
- panel_lat  out  1  panel latch strobe
- panel_oe_n  out  1  panel output enable, active low
- addr  out  5  panel row address (ABCDE)
- frame_start  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset values: state=IDLE; panel_oe_n=1; all other outputs 0 (plane=0, addr=0, rgb=0).
- Reset mid-operation returns to IDLE next cycle with OE blanked. scan_counters shares rst, so both restart at col 0, row 0.
- Panel outputs panel_clk, panel_lat, panel_oe_n and frame_start are registered. Each is asserted exactly during the cycles the FSM occupies the named state.
- col_inc and row_inc are decoded from the state register, so scan_counters updates at the end of that cycle.
- IDLE: oe_n=1. en=1 -> SETUP; otherwise stay.
- SETUP: capture rgb_top/rgb_bot into panel_rgb1/panel_rgb2 (visible next cycle); panel_clk=0 -> LO.
- LO: panel_clk=0; data stable -> HI.
- HI: panel_clk=1; col_inc=1. col_max=1 -> LATCH; else -> SETUP.
- Shift phase is therefore 3 cycles per column, 192 cycles per row. Data is stable one full cycle before and during the panel_clk high cycle.
- LATCH: panel_lat=1; oe_n=1; addr<=select_row; timer<=BASE_ON<<plane -> ON.
- ON: oe_n=0; timer decrements each cycle; at timer==1 -> ADV. oe_n is low for exactly BASE_ON<<plane cycles.
- ADV: oe_n=1; then update plane:
  - If plane==PWM_BITS-1: plane<=0 and row_inc=1.
  - If row_max is also 1: frame_start=1.
  - Otherwise plane<=plane+1.
  - Next state: en=1 -> SETUP; en=0 -> IDLE.
- en deasserted during shift or ON has no effect until ADV; the row/plane in flight always completes.
- Column wrap: col_max in HI with col_inc wraps select_col to 0 simultaneously with entering LATCH.
- Row wrap: row_inc at row 31 wraps select_row to 0; frame_start coincides.
- panel_lat and panel_oe_n=0 are never both asserted. panel_clk is never high in LATCH/ON/ADV.
- Cycle count per (row, plane p) = 192+1+(BASE_ON<<p)+1. Defaults: 210/226/258/322; row 1016; frame 32512.

Decomposition:
- Package led_panel_pkg:
  - state enum (IDLE, SETUP, LO, HI, LATCH, ON, ADV)
  - COL_W=6, ROW_W=5, N_COLS=64, N_ROWS=32
- Sub-module bcm_oe_timer: loadable down-counter with load value and done flag, width PLANE_W-independent (BASE_ON<<(PWM_BITS-1) must fit).

Test Plan:
- Reset with en=0 -> panel_oe_n=1, all other outputs 0, FSM stays IDLE, col_inc never pulses.
- en=1, rgb_top=3'b101, rgb_bot=3'b010 constant:
  - 64 panel_clk pulses, each high 1 cycle and low 2 cycles.
  - panel_rgb1=101 and panel_rgb2=010 at every rising edge.
  - Exactly one panel_lat pulse after the 64th; addr=0.
- Plane timing, defaults: successive oe_n-low widths on row 0 are 16, 32, 64, 128. row_inc pulses once after the 128-cycle window; next latch shows addr=1.
- Full frame, en=1 -> frame_start one pulse, 32512 cycles after the first SETUP. select_row and plane both back to 0; a second frame follows with identical timing.
- en dropped mid-shift of row 5 plane 2 -> row completes (64-cycle OE), ADV, then IDLE with oe_n=1. Re-asserting en resumes at row 5 plane 3.
- rst asserted during ON -> next cycle oe_n=1, state IDLE, plane=0, addr=0, scan_counters at 0/0.
